// File: rtl/abro_pkg.sv
// Shared definitions for the ABRO stimulus/checker: FSM encodings, golden-model
// state codes, the replayed vector table and the compare delay-line entry.
package abro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_DUT = 3'd1,
        ST_RUN       = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // Golden state: bit0 = A seen, bit1 = B seen since the last R.
    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_A    = 2'b01;
    localparam logic [1:0] AB_B    = 2'b10;
    localparam logic [1:0] AB_BOTH = 2'b11;

    localparam int unsigned VEC_N = 16;
    localparam int unsigned IDX_W = 4;

    // Each entry is {R, A, B}; played from index 0 upward.
    localparam logic [2:0] VEC_TABLE [VEC_N] = '{
        3'b000, 3'b100, 3'b000, 3'b001, 3'b010, 3'b000, 3'b100, 3'b011,
        3'b000, 3'b110, 3'b100, 3'b010, 3'b010, 3'b001, 3'b100, 3'b000
    };

    // One pending compare: expected O and the vector it belongs to.
    typedef struct packed {
        logic             vld;
        logic             exp_o;
        logic [IDX_W-1:0] idx;
    } cmp_ent_t;

endpackage

// File: rtl/abro_golden.sv
// Reference ABRO model used by the checker.
// Ports: Clock, Reset (sync, active-high); en qualifies an update from r/a/b;
// exp_o is the O the machine should present for the values being applied this
// cycle (post-update state == AB_BOTH); state is the current golden state.
module abro_golden
    import abro_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       en,
    input  logic       r,
    input  logic       a,
    input  logic       b,
    output logic       exp_o,
    output logic [1:0] state
);

    logic [1:0] state_d;
    logic [1:0] state_q;

    // R clears; otherwise A/B accumulate and stay set until the next R.
    always_comb begin
        state_d = state_q;
        if (en) begin
            if (r) begin
                state_d = AB_NONE;
            end else begin
                state_d = state_q | (a ? AB_A : AB_NONE) | (b ? AB_B : AB_NONE);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= AB_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    // Expected O reflects the state after this cycle's inputs are applied.
    assign exp_o = (state_d == AB_BOTH);
    assign state = state_q;

endmodule

// File: rtl/abro_stim_checker.sv
// On-chip stimulus generator and checker for an ABRO state machine.
// Ports: Clock, Reset (sync, active-high); start/abort control a run;
// R_out/A_out/B_out drive the machine, O_in is its O; busy/done report run
// status; pass_cnt/fail_cnt are saturating compare counters; first_fail holds
// the vector index of the first mismatch.
module abro_stim_checker
    import abro_pkg::*;
#(
    parameter int unsigned N_VEC   = 16,
    parameter int unsigned HOLD    = 2,
    parameter int unsigned RST_CYC = 2,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic             abort,
    output logic             R_out,
    output logic             A_out,
    output logic             B_out,
    input  logic             O_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [3:0]       first_fail
);

    localparam int unsigned CYC_MAX0 = (HOLD > RST_CYC) ? HOLD : RST_CYC;
    localparam int unsigned CYC_MAX  = (CYC_MAX0 > LATENCY) ? CYC_MAX0 : LATENCY;
    localparam int unsigned CYC_W    = $clog2(CYC_MAX + 1);
    localparam int unsigned DLY_D    = (LATENCY == 0) ? 1 : LATENCY;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [IDX_W-1:0] vec_q, vec_d;
    logic [2:0]       rab_q, rab_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [3:0]       ff_q, ff_d;
    cmp_ent_t         line_q [DLY_D];
    cmp_ent_t         line_d [DLY_D];
    cmp_ent_t         issue_c;
    cmp_ent_t         cmp_c;
    logic             abort_c;
    logic             clear_c;
    logic             gold_en_c;
    logic             gold_exp_c;
    logic [1:0]       gold_state_unused;

    assign abort_c   = abort && ((state_q == ST_RESET_DUT) || (state_q == ST_RUN) ||
                                 (state_q == ST_DRAIN));
    assign clear_c   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // R=1 throughout RESET_DUT, so enabling the model there forces it to AB_NONE.
    assign gold_en_c = (state_q == ST_RESET_DUT) || (state_q == ST_RUN);

    abro_golden u_golden (
        .Clock (Clock),
        .Reset (Reset),
        .en    (gold_en_c),
        .r     (rab_q[2]),
        .a     (rab_q[1]),
        .b     (rab_q[0]),
        .exp_o (gold_exp_c),
        .state (gold_state_unused)
    );

    // One compare is issued on the last hold cycle of each vector.
    always_comb begin
        issue_c.vld   = (state_q == ST_RUN) && (cyc_q == CYC_W'(HOLD - 1));
        issue_c.exp_o = gold_exp_c;
        issue_c.idx   = vec_q;
        cmp_c         = (LATENCY == 0) ? issue_c : line_q[DLY_D-1];
    end

    // Delay line aligning expected values with the machine's O latency.
    always_comb begin
        for (int k = 0; k < DLY_D; k++) begin
            line_d[k] = '0;
        end
        if (!abort_c) begin
            line_d[0] = issue_c;
            for (int k = 1; k < DLY_D; k++) begin
                line_d[k] = line_q[k-1];
            end
        end
    end

    // Next state, sequencing counters and registered drive/status outputs.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        vec_d   = vec_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RESET_DUT;
                    cyc_d   = '0;
                    vec_d   = '0;
                end
            end
            ST_RESET_DUT: begin
                if (cyc_q == CYC_W'(RST_CYC - 1)) begin
                    state_d = ST_RUN;
                    cyc_d   = '0;
                    vec_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_RUN: begin
                if (cyc_q == CYC_W'(HOLD - 1)) begin
                    cyc_d = '0;
                    if (vec_q == IDX_W'(N_VEC - 1)) begin
                        state_d = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
                    end else begin
                        vec_d = vec_q + IDX_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cyc_q == CYC_W'(LATENCY - 1)) begin
                    state_d = ST_DONE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_c) begin
            state_d = ST_DONE;
            cyc_d   = '0;
        end

        rab_d = 3'b000;
        if (state_d == ST_RESET_DUT) begin
            rab_d = 3'b100;
        end else if (state_d == ST_RUN) begin
            rab_d = VEC_TABLE[vec_d];
        end
        busy_d = (state_d == ST_RESET_DUT) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Scoreboard: saturating counters and first-mismatch capture.
    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        ff_d   = ff_q;
        if (clear_c) begin
            pass_d = '0;
            fail_d = '0;
            ff_d   = '0;
        end else if (cmp_c.vld && !abort_c) begin
            if (O_in == cmp_c.exp_o) begin
                if (pass_q != CNT_MAX) begin
                    pass_d = pass_q + CNT_W'(1);
                end
            end else begin
                if (fail_q != CNT_MAX) begin
                    fail_d = fail_q + CNT_W'(1);
                end
                if (fail_q == '0) begin
                    ff_d = cmp_c.idx;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            vec_q   <= '0;
            rab_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            ff_q    <= '0;
            for (int k = 0; k < DLY_D; k++) begin
                line_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            vec_q   <= vec_d;
            rab_q   <= rab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ff_q    <= ff_d;
            for (int k = 0; k < DLY_D; k++) begin
                line_q[k] <= line_d[k];
            end
        end
    end

    assign R_out      = rab_q[2];
    assign A_out      = rab_q[1];
    assign B_out      = rab_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_cnt   = pass_q;
    assign fail_cnt   = fail_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_abro_stim_checker.sv
// Bench for abro_stim_checker: four checker instances (default, LATENCY=0,
// LATENCY=3, CNT_W=2), each driving its own behavioural ABRO machine whose O
// delay and stuck-at-0 fault are controlled from the stimulus.
// Expected O per vector (post-update): 0,0,0,0,1,1,0,1,1,0,0,0,0,1,0,0.
module tb_abro_stim_checker;

    logic       clk;
    logic       rst;
    logic [3:0] start_v;
    logic       abort_a;
    logic [3:0] r_v, a_v, b_v, o_v, busy_v, done_v;
    logic [7:0] pass_a, fail_a, pass_b, fail_b, pass_c, fail_c;
    logic [1:0] pass_d, fail_d;
    logic [3:0] ff_a, ff_b, ff_c, ff_d;
    logic [2:0] dly [4];
    logic [3:0] stuck;

    int n_chk;
    int n_err;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    abro_stim_checker u_a (
        .Clock(clk), .Reset(rst), .start(start_v[0]), .abort(abort_a),
        .R_out(r_v[0]), .A_out(a_v[0]), .B_out(b_v[0]), .O_in(o_v[0]),
        .busy(busy_v[0]), .done(done_v[0]),
        .pass_cnt(pass_a), .fail_cnt(fail_a), .first_fail(ff_a)
    );

    abro_stim_checker #(.LATENCY(0)) u_b (
        .Clock(clk), .Reset(rst), .start(start_v[1]), .abort(1'b0),
        .R_out(r_v[1]), .A_out(a_v[1]), .B_out(b_v[1]), .O_in(o_v[1]),
        .busy(busy_v[1]), .done(done_v[1]),
        .pass_cnt(pass_b), .fail_cnt(fail_b), .first_fail(ff_b)
    );

    abro_stim_checker #(.LATENCY(3)) u_c (
        .Clock(clk), .Reset(rst), .start(start_v[2]), .abort(1'b0),
        .R_out(r_v[2]), .A_out(a_v[2]), .B_out(b_v[2]), .O_in(o_v[2]),
        .busy(busy_v[2]), .done(done_v[2]),
        .pass_cnt(pass_c), .fail_cnt(fail_c), .first_fail(ff_c)
    );

    abro_stim_checker #(.CNT_W(2)) u_d (
        .Clock(clk), .Reset(rst), .start(start_v[3]), .abort(1'b0),
        .R_out(r_v[3]), .A_out(a_v[3]), .B_out(b_v[3]), .O_in(o_v[3]),
        .busy(busy_v[3]), .done(done_v[3]),
        .pass_cnt(pass_d), .fail_cnt(fail_d), .first_fail(ff_d)
    );

    // Behavioural ABRO machines; O is the post-update flag delayed by dly[g] cycles.
    for (genvar g = 0; g < 4; g++) begin : g_abro
        logic [1:0] st;
        logic [1:0] nxt;
        logic [7:0] hist;
        logic [8:0] tap;
        assign nxt = r_v[g] ? 2'b00 : (st | {b_v[g], a_v[g]});
        assign tap = {hist, (nxt == 2'b11)};
        assign o_v[g] = stuck[g] ? 1'b0 : tap[dly[g]];
        always @(posedge clk) begin
            if (rst) begin
                st   <= 2'b00;
                hist <= '0;
            end else begin
                st   <= nxt;
                hist <= {hist[6:0], (nxt == 2'b11)};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_inst(input int g);
        start_v[g] = 1'b1;
        tick(1);
        start_v[g] = 1'b0;
    endtask

    // Counts busy cycles from the current one; bounded so a stuck run cannot hang.
    task automatic wait_idle(input int g, output int n);
        n = 0;
        while (busy_v[g] && n < 200) begin
            n++;
            tick(1);
        end
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b1;
        start_v = 4'b1111;
        abort_a = 1'b0;
        stuck   = 4'b0000;
        dly[0]  = 3'd1;
        dly[1]  = 3'd0;
        dly[2]  = 3'd3;
        dly[3]  = 3'd1;

        // Reset for three cycles with start asserted: start must be ignored.
        tick(1);
        start_v = 4'b0000;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst_busy_all", 32'(busy_v), 32'd0);
        chk("rst_done_all", 32'(done_v), 32'd0);
        chk("rst_rab_a", 32'({r_v[0], a_v[0], b_v[0]}), 32'd0);
        chk("rst_pass_a", 32'(pass_a), 32'd0);
        chk("rst_fail_a", 32'(fail_a), 32'd0);
        chk("rst_ff_a", 32'(ff_a), 32'd0);

        // Full run against a correct machine.
        start_inst(0);
        chk("a_busy_on_start", 32'(busy_v[0]), 32'd1);
        chk("a_rab_reset_dut", 32'({r_v[0], a_v[0], b_v[0]}), 32'b100);
        tick(16);
        chk("a_rab_vec7", 32'({r_v[0], a_v[0], b_v[0]}), 32'b011);
        wait_idle(0, cyc);
        chk("a_busy_cycles", 32'(16 + cyc), 32'd35);
        chk("a_done", 32'(done_v[0]), 32'd1);
        chk("a_pass", 32'(pass_a), 32'd16);
        chk("a_fail", 32'(fail_a), 32'd0);

        // Restart from DONE with O stuck at 0: the five O=1 vectors fail.
        stuck[0] = 1'b1;
        start_inst(0);
        chk("a_clr_pass", 32'(pass_a), 32'd0);
        chk("a_clr_done", 32'(done_v[0]), 32'd0);
        wait_idle(0, cyc);
        chk("stuck_pass", 32'(pass_a), 32'd11);
        chk("stuck_fail", 32'(fail_a), 32'd5);
        chk("stuck_first", 32'(ff_a), 32'd4);
        stuck[0] = 1'b0;

        // Abort on the 10th RUN cycle (overall cycle 12 after start).
        start_inst(0);
        tick(11);
        abort_a = 1'b1;
        tick(1);
        abort_a = 1'b0;
        chk("abort_done", 32'(done_v[0]), 32'd1);
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        chk("abort_rab", 32'({r_v[0], a_v[0], b_v[0]}), 32'd0);
        chk("abort_pass", 32'(pass_a), 32'd4);
        tick(4);
        chk("abort_pass_hold", 32'(pass_a), 32'd4);
        chk("abort_fail_hold", 32'(fail_a), 32'd0);

        // Reset mid-run wins over a simultaneous start.
        start_inst(0);
        tick(5);
        rst        = 1'b1;
        start_v[0] = 1'b1;
        tick(1);
        rst        = 1'b0;
        start_v[0] = 1'b0;
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        chk("midrst_pass", 32'(pass_a), 32'd0);
        chk("midrst_rab", 32'({r_v[0], a_v[0], b_v[0]}), 32'd0);
        tick(1);
        chk("midrst_idle", 32'(busy_v[0] | done_v[0]), 32'd0);

        // LATENCY=0 and LATENCY=3 with matching machine delay.
        start_inst(1);
        wait_idle(1, cyc);
        chk("l0_busy_cycles", 32'(cyc), 32'd34);
        chk("l0_pass", 32'(pass_b), 32'd16);
        chk("l0_fail", 32'(fail_b), 32'd0);
        start_inst(2);
        wait_idle(2, cyc);
        chk("l3_busy_cycles", 32'(cyc), 32'd37);
        chk("l3_pass", 32'(pass_c), 32'd16);
        chk("l3_fail", 32'(fail_c), 32'd0);

        // Machine one cycle early: O shows the next vector's value.
        dly[2] = 3'd2;
        start_inst(2);
        wait_idle(2, cyc);
        chk("l3_early_pass", 32'(pass_c), 32'd10);
        chk("l3_early_fail", 32'(fail_c), 32'd6);
        chk("l3_early_first", 32'(ff_c), 32'd3);

        // CNT_W=2: back-to-back runs, each restart clears, counters saturate at 3.
        for (int run = 0; run < 3; run++) begin
            stuck[3] = (run == 2);
            start_inst(3);
            chk("d_clr_pass", 32'(pass_d), 32'd0);
            chk("d_clr_fail", 32'(fail_d), 32'd0);
            wait_idle(3, cyc);
            chk("d_pass_sat", 32'(pass_d), 32'd3);
            chk("d_fail", 32'(fail_d), (run == 2) ? 32'd3 : 32'd0);
        end
        chk("d_first", 32'(ff_d), 32'd4);
        chk("d_done_not_busy", 32'({busy_v[3], done_v[3]}), 32'b01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
